// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: two requesters share one single-ported data memory.
// Each access takes a fixed three cycles: IDLE (accept), ACCESS (memory
// enabled) and RESP (one-cycle completion pulse to the owner).
// All memory-side controls are driven from flops so they cannot glitch.
// Optional feature: define MEM_ARB_ROUND_ROBIN_EN to alternate the winner on
// simultaneous requests. Without it, r0 has fixed priority.
module mem_port_arbiter #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              r0_valid,
  output logic              r0_ready,
  input  logic              r0_we,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  input  logic              r1_valid,
  output logic              r1_ready,
  input  logic              r1_we,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              r0_rsp_valid,
  output logic              r1_rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              CEN,
  output logic              WEN,
  output logic              OEN,
  output logic [ADDR_W-1:0] A,
  output logic [DATA_W-1:0] Data2Mem,
  input  logic [DATA_W-1:0] ReadDataMem
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                owner_q, owner_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   a_q, a_d;
  logic [DATA_W-1:0]   data2mem_q, data2mem_d;
  logic                cen_q, cen_d;
  logic                wen_q, wen_d;
  logic                oen_q, oen_d;
  logic                rsp0_q, rsp0_d;
  logic                rsp1_q, rsp1_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // 1 = r1 received the most recent grant, so r0 wins the next tie.
  logic                last_q, last_d;
`endif

  logic                grant0;
  logic                grant1;
  logic                sel_we;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;

  // Arbitration: only in IDLE and never while reset is held.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state_q == IDLE && rst_n) begin
      if (r0_valid && r1_valid) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
        grant0 = last_q;
        grant1 = ~last_q;
`else
        grant0 = 1'b1;
`endif
      end else begin
        grant0 = r0_valid;
        grant1 = r1_valid;
      end
    end
  end

  assign r0_ready = grant0;
  assign r1_ready = grant1;

  // Command mux feeding the capture registers.
  always_comb begin
    sel_we    = grant1 ? r1_we    : r0_we;
    sel_addr  = grant1 ? r1_addr  : r0_addr;
    sel_wdata = grant1 ? r1_wdata : r0_wdata;
  end

  // Next-state and next-output computation for the access sequencer.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    we_d       = we_q;
    a_d        = a_q;
    data2mem_d = data2mem_q;
    cen_d      = 1'b1;
    wen_d      = 1'b1;
    oen_d      = 1'b1;
    rsp0_d     = 1'b0;
    rsp1_d     = 1'b0;
    rdata_d    = rdata_q;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    last_d     = last_q;
`endif
    case (state_q)
      IDLE: begin
        if (grant0 || grant1) begin
          state_d    = ACCESS;
          owner_d    = grant1;
          we_d       = sel_we;
          a_d        = sel_addr;
          data2mem_d = sel_wdata;
          cen_d      = 1'b0;
          wen_d      = ~sel_we;
          oen_d      = sel_we;
`ifdef MEM_ARB_ROUND_ROBIN_EN
          last_d     = grant1;
`endif
        end
      end
      ACCESS: begin
        // Memory is enabled this cycle; read data is taken at its end.
        state_d = RESP;
        rsp0_d  = ~owner_q;
        rsp1_d  = owner_q;
        if (!we_q) begin
          rdata_d = ReadDataMem;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs; reset aborts any access in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      owner_q    <= 1'b0;
      we_q       <= 1'b0;
      a_q        <= '0;
      data2mem_q <= '0;
      cen_q      <= 1'b1;
      wen_q      <= 1'b1;
      oen_q      <= 1'b1;
      rsp0_q     <= 1'b0;
      rsp1_q     <= 1'b0;
      rdata_q    <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_q     <= 1'b1;
`endif
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      we_q       <= we_d;
      a_q        <= a_d;
      data2mem_q <= data2mem_d;
      cen_q      <= cen_d;
      wen_q      <= wen_d;
      oen_q      <= oen_d;
      rsp0_q     <= rsp0_d;
      rsp1_q     <= rsp1_d;
      rdata_q    <= rdata_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_q     <= last_d;
`endif
    end
  end

  assign CEN          = cen_q;
  assign WEN          = wen_q;
  assign OEN          = oen_q;
  assign A            = a_q;
  assign Data2Mem     = data2mem_q;
  assign r0_rsp_valid = rsp0_q;
  assign r1_rsp_valid = rsp1_q;
  assign rsp_rdata    = rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: transaction-level model (age of the current
// access in cycles) compared on every falling edge, directed scenarios with
// literal expectations, then randomized traffic with occasional resets.
// Honours MEM_ARB_ROUND_ROBIN_EN the same way as the design.
module tb_mem_port_arbiter;
  localparam int AW = 7;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          r0_valid, r1_valid, r0_we, r1_we;
  logic [AW-1:0] r0_addr, r1_addr;
  logic [DW-1:0] r0_wdata, r1_wdata;
  logic          r0_ready, r1_ready, r0_rsp_valid, r1_rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          CEN, WEN, OEN;
  logic [AW-1:0] A;
  logic [DW-1:0] Data2Mem;
  logic [DW-1:0] ReadDataMem;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_we(r0_we),
    .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_we(r1_we),
    .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r0_rsp_valid(r0_rsp_valid), .r1_rsp_valid(r1_rsp_valid),
    .rsp_rdata(rsp_rdata),
    .CEN(CEN), .WEN(WEN), .OEN(OEN), .A(A), .Data2Mem(Data2Mem),
    .ReadDataMem(ReadDataMem)
  );

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory device: write at the clock edge, read data presented while enabled.
  logic [DW-1:0] dev_mem [128];
  bit            mem_init;
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 128; i++) dev_mem[i] <= 32'h1000_0000 + i * 32'h0101_0101;
    end else if (!CEN && !WEN) begin
      dev_mem[A] <= Data2Mem;
    end
  end
  assign ReadDataMem = (!CEN && !OEN) ? dev_mem[A] : 32'h0BAD_F00D;

  // Reference model: age = cycles since acceptance (0 = no access in flight).
  logic [DW-1:0] model_mem [128];
  int            age;
  bit            m_owner, m_we, m_last, gnt0, gnt1, check_en;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_rdata;

  // Compare process: every falling edge once checking is enabled.
  always @(negedge clk) begin
    if (check_en) begin
      if (!rst_n) begin
        chk("rst_CEN", {31'd0, CEN}, 1);
        chk("rst_WEN", {31'd0, WEN}, 1);
        chk("rst_OEN", {31'd0, OEN}, 1);
        chk("rst_A", {25'd0, A}, 0);
        chk("rst_Data2Mem", Data2Mem, 0);
        chk("rst_rdata", rsp_rdata, 0);
        chk("rst_rsp", {30'd0, r1_rsp_valid, r0_rsp_valid}, 0);
        chk("rst_ready", {30'd0, r1_ready, r0_ready}, 0);
        if (mem_init)
          for (int i = 0; i < 128; i++) model_mem[i] = 32'h1000_0000 + i * 32'h0101_0101;
        age = 0; m_last = 1'b1; m_owner = 1'b0; m_we = 1'b0;
        m_addr = '0; m_wdata = '0; m_rdata = '0;
      end else begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (age == 0) begin
          if (r0_valid && r1_valid) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            if (m_last) gnt0 = 1'b1; else gnt1 = 1'b1;
`else
            gnt0 = 1'b1;
`endif
          end else begin
            gnt0 = r0_valid;
            gnt1 = r1_valid;
          end
        end
        chk("r0_ready", {31'd0, r0_ready}, {31'd0, gnt0});
        chk("r1_ready", {31'd0, r1_ready}, {31'd0, gnt1});
        chk("CEN", {31'd0, CEN}, (age == 1) ? 0 : 1);
        chk("WEN", {31'd0, WEN}, (age == 1 && m_we) ? 0 : 1);
        chk("OEN", {31'd0, OEN}, (age == 1 && !m_we) ? 0 : 1);
        chk("A", {25'd0, A}, {25'd0, m_addr});
        chk("Data2Mem", Data2Mem, m_wdata);
        chk("r0_rsp_valid", {31'd0, r0_rsp_valid}, (age == 2 && !m_owner) ? 1 : 0);
        chk("r1_rsp_valid", {31'd0, r1_rsp_valid}, (age == 2 && m_owner) ? 1 : 0);
        chk("rsp_rdata", rsp_rdata, m_rdata);
        case (age)
          0: if (gnt0 || gnt1) begin
               age = 1;
               m_owner = gnt1;
               m_last = gnt1;
               m_we = gnt1 ? r1_we : r0_we;
               m_addr = gnt1 ? r1_addr : r0_addr;
               m_wdata = gnt1 ? r1_wdata : r0_wdata;
             end
          1: begin
               if (m_we) model_mem[m_addr] = m_wdata;
               else m_rdata = model_mem[m_addr];
               age = 2;
             end
          default: age = 0;
        endcase
      end
    end
  end

  task automatic set0(input bit v, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    r0_valid = v; r0_we = we; r0_addr = a; r0_wdata = d;
  endtask
  task automatic set1(input bit v, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    r1_valid = v; r1_we = we; r1_addr = a; r1_wdata = d;
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int  g_cnt;
  int  g_who [4];
  int  g_cyc [4];
  int  r1_seen;
  bit  rr_exp [4];

  initial begin
    rst_n = 1'b0;
    mem_init = 1'b1;
    check_en = 1'b0;
    set0(0, 0, 0, 0);
    set1(0, 0, 0, 0);
    repeat (2) @(posedge clk);
    check_en = 1'b1;
    @(negedge clk);
    chk("lit_reset_CEN", {31'd0, CEN}, 1);
    chk("lit_reset_rdata", rsp_rdata, 0);
    step();
    mem_init = 1'b0;
    rst_n = 1'b1;

    // r0 write addr 5
    set0(1, 1, 5, 32'hDEAD_BEEF);
    @(negedge clk);
    chk("lit_w_ready", {31'd0, r0_ready}, 1);
    step();
    set0(0, 0, 0, 0);
    @(negedge clk);
    chk("lit_w_ctl", {29'd0, CEN, WEN, OEN}, 3'b001);
    chk("lit_w_A", {25'd0, A}, 5);
    chk("lit_w_D", Data2Mem, 32'hDEAD_BEEF);
    @(negedge clk);
    chk("lit_w_rsp", {30'd0, r1_rsp_valid, r0_rsp_valid}, 2'b01);
    step();

    // r1 read addr 5
    set1(1, 0, 5, 0);
    @(negedge clk);
    chk("lit_r_ready", {30'd0, r1_ready, r0_ready}, 2'b10);
    step();
    set1(0, 0, 0, 0);
    @(negedge clk);
    chk("lit_r_ctl", {29'd0, CEN, WEN, OEN}, 3'b010);
    @(negedge clk);
    chk("lit_r_rsp", {30'd0, r1_rsp_valid, r0_rsp_valid}, 2'b10);
    chk("lit_r_rdata", rsp_rdata, 32'hDEAD_BEEF);
    step();

    // Continuous contention: grants at cycles 0,3,6,9
    set0(1, 0, 7'($urandom_range(0, 15)), 0);
    set1(1, 0, 7'($urandom_range(0, 15)), 0);
    g_cnt = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if ((r0_ready || r1_ready) && g_cnt < 4) begin
        g_who[g_cnt] = r1_ready ? 1 : 0;
        g_cyc[g_cnt] = c;
        g_cnt++;
      end
      step();
    end
    set0(0, 0, 0, 0);
    set1(0, 0, 0, 0);
`ifdef MEM_ARB_ROUND_ROBIN_EN
    rr_exp = '{0, 1, 0, 1};
`else
    rr_exp = '{0, 0, 0, 0};
`endif
    chk("lit_cont_count", g_cnt, 4);
    for (int k = 0; k < 4; k++) begin
      if (k < g_cnt) begin
        chk("lit_cont_who", g_who[k], {31'd0, rr_exp[k]});
        chk("lit_cont_cycle", g_cyc[k], 3 * k);
      end
    end

    // Reset during ACCESS of an r0 read; r0 keeps requesting throughout
    set0(1, 0, 5, 0);
    @(negedge clk);
    chk("lit_rst_acc_ready", {31'd0, r0_ready}, 1);
    step();
    rst_n = 1'b0;
    #1;
    chk("lit_rst_CEN_now", {31'd0, CEN}, 1);
    chk("lit_rst_OEN_now", {31'd0, OEN}, 1);
    @(negedge clk);
    chk("lit_rst_no_grant", {31'd0, r0_ready}, 0);
    chk("lit_rst_no_rsp", {31'd0, r0_rsp_valid}, 0);
    step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("lit_rst_after_rsp", {31'd0, r0_rsp_valid}, 0);
    chk("lit_rst_regrant", {31'd0, r0_ready}, 1);
    step();
    set0(0, 0, 0, 0);
    @(negedge clk);
    chk("lit_rst_after_OEN", {31'd0, OEN}, 0);
    @(negedge clk);
    chk("lit_rst_after_rsp2", {31'd0, r0_rsp_valid}, 1);
    chk("lit_rst_after_rdata", rsp_rdata, 32'hDEAD_BEEF);
    step();

    // r1 valid for one cycle during ACCESS, then dropped
    set0(1, 1, 9, $urandom);
    @(negedge clk);
    step();
    set0(0, 0, 0, 0);
    set1(1, 0, 3, 0);
    step();
    set1(0, 0, 0, 0);
    r1_seen = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (r1_ready || r1_rsp_valid) r1_seen++;
    end
    chk("lit_drop_r1", r1_seen, 0);
    step();

    // Randomized traffic with occasional reset pulses
    for (int c = 0; c < 600; c++) begin
      rst_n = ($urandom_range(0, 79) == 0) ? 1'b0 : 1'b1;
      set0($urandom_range(0, 9) < 6, $urandom_range(0, 1) == 1, 7'($urandom_range(0, 15)), $urandom);
      set1($urandom_range(0, 9) < 6, $urandom_range(0, 1) == 1, 7'($urandom_range(0, 15)), $urandom);
      step();
    end
    rst_n = 1'b1;
    set0(0, 0, 0, 0);
    set1(0, 0, 0, 0);
    repeat (4) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter ADDR_W, default 7: word-address width of the shared data-memory port.
REQ-002 Parameter DATA_W, default 32: data width of the memory port and requester data paths.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 r0_valid, r1_valid  input  1 each  requester n presents a command.
REQ-006 r0_ready, r1_ready  output  1 each  command of requester n is accepted this cycle.
REQ-007 r0_we, r1_we  input  1 each  1 = write, 0 = read.
REQ-008 r0_addr, r1_addr  input  ADDR_W each  word address.
REQ-009 r0_wdata, r1_wdata  input  DATA_W each  write data.
REQ-010 r0_rsp_valid, r1_rsp_valid  output  1 each  one-cycle completion pulse for requester n.
REQ-011 rsp_rdata  output  DATA_W  read data, valid while rsp_valid of the owner is high.
REQ-012 CEN, WEN, OEN  output  1 each  active-low chip, write and output enables to memory.
REQ-013 A  output  ADDR_W  memory address.
REQ-014 Data2Mem  output  DATA_W  memory write data.
REQ-015 ReadDataMem  input  DATA_W  memory read data; valid one cycle after a read is enabled.

Function
REQ-016 The FSM SHALL have states IDLE, ACCESS and RESP; at most one access is outstanding.
REQ-017 In IDLE, if any rn_valid is high, exactly one rn_ready SHALL be driven high combinationally for the winner; the FSM then moves to ACCESS.
REQ-018 On acceptance, owner id, we, addr and wdata SHALL be registered; requester inputs are ignored afterwards.
REQ-019 In ACCESS: CEN=0; WEN=0 only for a write; OEN=0 only for a read; A and Data2Mem from the registered command. Next state is RESP.
REQ-020 In RESP: CEN=WEN=OEN=1; the owner's rsp_valid SHALL be high for exactly one cycle; for reads rsp_rdata SHALL capture ReadDataMem sampled at the end of ACCESS. Next state is IDLE.
REQ-021 For writes, rsp_rdata SHALL hold its previous value.
REQ-022 rn_ready SHALL be 0 in ACCESS and RESP; maximum throughput is one access per 3 cycles.
REQ-023 Fixed latency: acceptance at edge N, memory enabled in cycle N+1, rsp_valid in cycle N+2.
REQ-024 CEN, WEN, OEN, A and Data2Mem SHALL be registered outputs (glitch-free).
REQ-025 A requester whose valid drops before acceptance SHALL NOT be granted; no state change results.

Reset
REQ-026 Asserting rst_n low SHALL immediately force IDLE, CEN=WEN=OEN=1, A=0, Data2Mem=0, rsp_rdata=0, all rsp_valid=0 and the priority pointer to favour r0.
REQ-027 Reset asserted during ACCESS or RESP SHALL abort the access with no rsp_valid pulse, including after deassertion.
REQ-028 The first grant after reset deassertion SHALL occur no earlier than the first rising edge with rst_n high.

Configuration
REQ-029 With MEM_ARB_ROUND_ROBIN_EN defined, on simultaneous valid the requester not granted last SHALL win, and the pointer updates on every grant.
REQ-030 Without MEM_ARB_ROUND_ROBIN_EN, r0 SHALL always win on simultaneous valid and no pointer register exists.
REQ-031 Single-requester behaviour SHALL be identical in both configurations.

Verification
REQ-032 r0 write addr=5 data=0xDEADBEEF -> cycle N+1 CEN=0 WEN=0 OEN=1 A=5 Data2Mem=0xDEADBEEF; r0_rsp_valid pulses in N+2.
REQ-033 r1 read addr=5, model returns 0xDEADBEEF -> OEN=0 in N+1; r1_rsp_valid=1 and rsp_rdata=0xDEADBEEF in N+2; r0_rsp_valid stays 0.
REQ-034 r0 and r1 valid continuously, with round-robin -> grant order r0,r1,r0,r1 at 3-cycle spacing; without the macro -> r0 every grant, r1 starved.
REQ-035 r0 read accepted, rst_n pulsed low during ACCESS -> CEN=1 at once, no rsp_valid, FSM IDLE; next request is served normally.
REQ-036 r1 valid for one cycle during ACCESS, then dropped -> r1 never granted, no r1_rsp_valid.
